// File: rtl/psum_drain.sv
// Drains column partial-sum words from the output FIFO into the psum SRAM,
// either overwriting or accumulating (read-modify-write) at consecutive addresses.
module psum_drain #(
  parameter int unsigned psum_bw = 16,
  parameter int unsigned col     = 4,
  parameter int unsigned addr_bw = 11
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   acc,
  input  logic [addr_bw-1:0]     base_addr,
  input  logic [addr_bw-1:0]     num_rows,
  input  logic                   o_valid,
  input  logic [col*psum_bw-1:0] psum_in,
  output logic                   rd_ofifo,
  output logic                   mem_en,
  output logic                   mem_wen,
  output logic [addr_bw-1:0]     mem_addr,
  output logic [col*psum_bw-1:0] mem_din,
  input  logic [col*psum_bw-1:0] mem_dout,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned data_w = col * psum_bw;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    POP  = 3'd1,
    RD   = 3'd2,
    WAIT = 3'd3,
    WR   = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t              state;
  logic [addr_bw-1:0]  cnt;
  logic [data_w-1:0]   data_q;
  logic                acc_q;
  logic [addr_bw-1:0]  base_q;
  logic [addr_bw-1:0]  rows_q;
  logic [addr_bw-1:0]  addr_sum;

  // Address wraps modulo 2^addr_bw by truncation.
  assign addr_sum = base_q + cnt;

  // Job sequencing and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      data_q <= '0;
      acc_q  <= 1'b0;
      base_q <= '0;
      rows_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc_q  <= acc;
            base_q <= base_addr;
            rows_q <= num_rows;
            cnt    <= '0;
            state  <= (num_rows == '0) ? DONE : POP;
          end
        end
        POP: begin
          if (o_valid) begin
            data_q <= psum_in;
            state  <= acc_q ? RD : WR;
          end
        end
        RD: state <= WAIT;
        WAIT: begin
          // Per-lane wrapping add of the SRAM word read in RD.
          for (int i = 0; i < int'(col); i++) begin
            data_q[i*psum_bw +: psum_bw] <= data_q[i*psum_bw +: psum_bw]
                                          + mem_dout[i*psum_bw +: psum_bw];
          end
          state <= WR;
        end
        WR: begin
          if (cnt == rows_q - addr_bw'(1)) begin
            state <= DONE;
          end else begin
            cnt   <= cnt + addr_bw'(1);
            state <= POP;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Output decode from state and registers.
  always_comb begin
    rd_ofifo = 1'b0;
    mem_en   = 1'b0;
    mem_wen  = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    busy     = (state != IDLE);
    done     = 1'b0;
    case (state)
      POP: rd_ofifo = o_valid;
      RD: begin
        mem_en   = 1'b1;
        mem_addr = addr_sum;
      end
      WR: begin
        mem_en   = 1'b1;
        mem_wen  = 1'b1;
        mem_addr = addr_sum;
        mem_din  = data_q;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_psum_drain.sv
// Directed self-checking bench for psum_drain with a behavioural SRAM and show-ahead FIFO.
module tb_psum_drain;

  localparam int unsigned PB  = 16;
  localparam int unsigned COL = 4;
  localparam int unsigned AB  = 11;
  localparam int unsigned DW  = PB * COL;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          acc;
  logic [AB-1:0] base_addr;
  logic [AB-1:0] num_rows;
  logic          o_valid;
  logic [DW-1:0] psum_in;
  logic          rd_ofifo;
  logic          mem_en;
  logic          mem_wen;
  logic [AB-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  psum_drain #(.psum_bw(PB), .col(COL), .addr_bw(AB)) dut (
    .clk(clk), .reset(reset), .start(start), .acc(acc),
    .base_addr(base_addr), .num_rows(num_rows), .o_valid(o_valid),
    .psum_in(psum_in), .rd_ofifo(rd_ofifo), .mem_en(mem_en),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .busy(busy), .done(done)
  );

  // Single-port synchronous SRAM, 1-cycle read latency.
  logic [DW-1:0] mem [0:(1<<AB)-1];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_wen) mem[mem_addr] <= mem_din;
      else         mem_dout <= mem[mem_addr];
    end
  end

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] fifo[$];
  bit            vp [0:31];
  int            pops, bad_pops, busy_cnt, en_cnt, done_cnt, done_cyc;
  int            wr_cyc[$], wr_addr[$], rd_cyc[$], rd_addr[$];
  logic [DW-1:0] wr_data[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic sample(input int off);
    #1;
    if (rd_ofifo) begin
      pops++;
      if (!o_valid) bad_pops++;
      else if (fifo.size() > 0) void'(fifo.pop_front());
    end
    if (busy) busy_cnt++;
    if (mem_en) begin
      en_cnt++;
      if (mem_wen) begin
        wr_cyc.push_back(off);
        wr_addr.push_back(int'(mem_addr));
        wr_data.push_back(mem_din);
      end else begin
        rd_cyc.push_back(off);
        rd_addr.push_back(int'(mem_addr));
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = off;
    end
  endtask

  // Runs a fixed number of cycles from a start pulse at offset 0.
  task automatic run_job(input bit a, input int base, input int rows, input int ncyc,
                         input int start_again, input int rst_at);
    pops = 0; bad_pops = 0; busy_cnt = 0; en_cnt = 0; done_cnt = 0; done_cyc = -1;
    wr_cyc.delete(); wr_addr.delete(); wr_data.delete(); rd_cyc.delete(); rd_addr.delete();
    acc = a; base_addr = AB'(base); num_rows = AB'(rows);
    for (int off = 0; off < ncyc; off++) begin
      start = (off == 0) || (off == start_again);
      if (off == start_again) begin
        base_addr = AB'(500); num_rows = '0; acc = ~a;
      end
      reset   = (off == rst_at);
      o_valid = vp[off] && (fifo.size() > 0);
      psum_in = (fifo.size() > 0) ? fifo[0] : '0;
      sample(off);
      if (rst_at >= 0 && off == rst_at + 1) begin
        check("rst_outputs", {57'd0, rd_ofifo, mem_en, mem_wen, busy, done, |mem_addr, |mem_din}, 64'd0);
      end
      @(negedge clk);
    end
    start = 1'b0; reset = 1'b0;
  endtask

  task automatic set_vp_all();
    for (int i = 0; i < 32; i++) vp[i] = 1'b1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; acc = 1'b0; base_addr = '0; num_rows = '0;
    o_valid = 1'b0; psum_in = '0; mem_dout = '0;
    for (int i = 0; i < (1 << AB); i++) mem[i] = '0;
    set_vp_all();
    @(negedge clk); @(negedge clk);
    #1;
    check("reset_outputs", {57'd0, rd_ofifo, mem_en, mem_wen, busy, done, |mem_addr, |mem_din}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Overwrite, 3 rows at base 10.
    fifo = '{64'h0001_0002_0003_0004, 64'h0002_0003_0004_0005, 64'h0003_0004_0005_0006};
    run_job(1'b0, 10, 3, 10, -1, -1);
    check("ow_nwr", 64'(wr_cyc.size()), 64'd3);
    check("ow_cyc0", 64'(wr_cyc[0]), 64'd2);
    check("ow_cyc1", 64'(wr_cyc[1]), 64'd4);
    check("ow_cyc2", 64'(wr_cyc[2]), 64'd6);
    check("ow_addr0", 64'(wr_addr[0]), 64'd10);
    check("ow_addr1", 64'(wr_addr[1]), 64'd11);
    check("ow_addr2", 64'(wr_addr[2]), 64'd12);
    check("ow_data0", wr_data[0], 64'h0001_0002_0003_0004);
    check("ow_data2", wr_data[2], 64'h0003_0004_0005_0006);
    check("ow_mem11", mem[11], 64'h0002_0003_0004_0005);
    check("ow_done_cyc", 64'(done_cyc), 64'd7);
    check("ow_done_cnt", 64'(done_cnt), 64'd1);
    check("ow_pops", 64'(pops), 64'd3);
    check("ow_en_cnt", 64'(en_cnt), 64'd3);

    // Accumulate, 1 row at address 5, lane 2 wraps.
    mem[5] = 64'h0000_7FFF_FFFD_0064;
    fifo = '{64'hFFFF_0001_0003_0001};
    run_job(1'b1, 5, 1, 8, -1, -1);
    check("acc_nrd", 64'(rd_cyc.size()), 64'd1);
    check("acc_rd_cyc", 64'(rd_cyc[0]), 64'd2);
    check("acc_rd_addr", 64'(rd_addr[0]), 64'd5);
    check("acc_wr_cyc", 64'(wr_cyc[0]), 64'd4);
    check("acc_wr_addr", 64'(wr_addr[0]), 64'd5);
    check("acc_wr_data", wr_data[0], 64'hFFFF_8000_0000_0065);
    check("acc_mem5", mem[5], 64'hFFFF_8000_0000_0065);
    check("acc_done_cyc", 64'(done_cyc), 64'd5);

    // o_valid 1,0,0,1 stalls POP; a start pulse while stalled is ignored.
    set_vp_all(); vp[2] = 1'b0; vp[3] = 1'b0;
    fifo = '{64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888};
    run_job(1'b0, 20, 2, 9, 3, -1);
    check("stl_nwr", 64'(wr_cyc.size()), 64'd2);
    check("stl_cyc0", 64'(wr_cyc[0]), 64'd2);
    check("stl_cyc1", 64'(wr_cyc[1]), 64'd5);
    check("stl_addr1", 64'(wr_addr[1]), 64'd21);
    check("stl_data1", wr_data[1], 64'h5555_6666_7777_8888);
    check("stl_done_cyc", 64'(done_cyc), 64'd6);
    check("stl_pops", 64'(pops), 64'd2);
    check("stl_bad_pops", 64'(bad_pops), 64'd0);
    set_vp_all();

    // Zero-row job completes immediately.
    fifo = '{64'hDEAD_BEEF_0000_0001};
    run_job(1'b0, 7, 0, 4, -1, -1);
    check("zero_done_cyc", 64'(done_cyc), 64'd1);
    check("zero_done_cnt", 64'(done_cnt), 64'd1);
    check("zero_busy", 64'(busy_cnt), 64'd1);
    check("zero_pops", 64'(pops), 64'd0);
    check("zero_en", 64'(en_cnt), 64'd0);

    // Address wraps from the top of memory to 0.
    fifo = '{64'h0A0A_0B0B_0C0C_0D0D, 64'h0E0E_0F0F_1010_1111};
    run_job(1'b0, 2047, 2, 7, -1, -1);
    check("wrap_addr0", 64'(wr_addr[0]), 64'd2047);
    check("wrap_addr1", 64'(wr_addr[1]), 64'd0);
    check("wrap_mem0", mem[0], 64'h0E0E_0F0F_1010_1111);

    // Reset during WAIT aborts the job with no write.
    mem[100] = 64'h0123_4567_89AB_CDEF;
    fifo = '{64'h0001_0001_0001_0001, 64'h0002_0002_0002_0002};
    run_job(1'b1, 100, 2, 8, -1, 3);
    check("rst_nrd", 64'(rd_cyc.size()), 64'd1);
    check("rst_rd_addr", 64'(rd_addr[0]), 64'd100);
    check("rst_nwr", 64'(wr_cyc.size()), 64'd0);
    check("rst_done", 64'(done_cnt), 64'd0);
    check("rst_pops", 64'(pops), 64'd1);
    check("rst_mem100", mem[100], 64'h0123_4567_89AB_CDEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
